baggage_drop_timer: RTL and testbench



---
 rtl/baggage_pkg.sv | 29 ++
 rtl/drop_tick_gen.sv | 29 ++
 rtl/baggage_drop_timer.sv | 118 +++++++++++
 tb/tb_baggage_drop_timer.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/baggage_pkg.sv
// Shared types and constants for the baggage drop timer and its drop/display stage.
package baggage_pkg;

  localparam int T_WIDTH = 16;
  localparam logic [T_WIDTH-1:0] T_SAT = 16'hFFFF;

  typedef enum logic [2:0] {
    IDLE,
    COUNT,
    DROP,
    HOLD,
    DONE,
    FAIL
  } state_e;

  // Seven-segment glyphs, segment order {g,f,e,d,c,b,a}, active-high.
  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_A     = 7'h77;
  localparam logic [6:0] SEG_D     = 7'h5E;
  localparam logic [6:0] SEG_E     = 7'h79;
  localparam logic [6:0] SEG_F     = 7'h71;
  localparam logic [6:0] SEG_L     = 7'h38;
  localparam logic [6:0] SEG_N     = 7'h54;
  localparam logic [6:0] SEG_O     = 7'h5C;

endpackage

// File: rtl/drop_tick_gen.sv
// Prescaler producing a one-cycle tick every TICK_DIV enabled cycles.
module drop_tick_gen #(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/baggage_drop_timer.sv
// Baggage cycle timer: measures elapsed ticks, latches the limit and runs the
// drop_en / drop_activated handshake with the drop/display stage.
module baggage_drop_timer
  import baggage_pkg::*;
#(
  parameter int TICK_DIV  = 4,
  parameter int DROP_HOLD = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [T_WIDTH-1:0] t_lim_in,
  input  logic               drop_req,
  input  logic               drop_activated,
  output logic [T_WIDTH-1:0] t_act,
  output logic [T_WIDTH-1:0] t_lim,
  output logic               drop_en,
  output logic               busy,
  output logic               done,
  output logic               fail
);

  localparam int HW = $clog2(DROP_HOLD + 2);
  localparam logic [HW-1:0] HOLD_LAST = HW'(DROP_HOLD);

  state_e        state;
  logic [HW-1:0] hold_cnt;
  logic          tick;
  logic          tick_clr;
  logic          tick_en;

  function automatic logic [T_WIDTH-1:0] sat_inc(input logic [T_WIDTH-1:0] v);
    return (v == T_SAT) ? v : v + 1'b1;
  endfunction

  // drop_req wins over the tick in the same cycle, which freezes t_act.
  assign tick_clr = (state == IDLE) && start;
  assign tick_en  = (state == COUNT) && !drop_req;

  drop_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (tick_clr),
    .en   (tick_en),
    .tick (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      t_act    <= '0;
      t_lim    <= '0;
      hold_cnt <= '0;
      drop_en  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      fail     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            t_lim <= t_lim_in;
            t_act <= '0;
            busy  <= 1'b1;
            state <= COUNT;
          end
        end
        COUNT: begin
          if (drop_req) begin
            drop_en <= 1'b1;
            state   <= DROP;
          end else if (tick) begin
            t_act <= sat_inc(t_act);
          end
        end
        DROP: begin
          if (drop_activated) begin
            hold_cnt <= '0;
            state    <= HOLD;
          end else begin
            drop_en <= 1'b0;
            fail    <= 1'b1;
            state   <= FAIL;
          end
        end
        HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            drop_en <= 1'b0;
            done    <= 1'b1;
            state   <= DONE;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        FAIL: begin
          fail  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          drop_en <= 1'b0;
          busy    <= 1'b0;
          done    <= 1'b0;
          fail    <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_baggage_drop_timer.sv
// Bench for baggage_drop_timer: two instances (TICK_DIV=4/DROP_HOLD=3 and
// TICK_DIV=1/DROP_HOLD=0) against a closed-form timing model.
module tb_baggage_drop_timer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        st4, dr4, st1, dr1;
  logic [15:0] lm4, lm1;
  logic [15:0] tact4, tlim4, tact1, tlim1;
  logic        en4, busy4, done4, fail4;
  logic        en1, busy1, done1, fail1;
  logic        da4, da1;

  // Drop/display stage behaviour seen by the timer.
  assign da4 = (tact4 <= tlim4) && en4;
  assign da1 = (tact1 <= tlim1) && en1;

  baggage_drop_timer #(.TICK_DIV(4), .DROP_HOLD(3)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(st4), .t_lim_in(lm4), .drop_req(dr4),
    .drop_activated(da4), .t_act(tact4), .t_lim(tlim4), .drop_en(en4),
    .busy(busy4), .done(done4), .fail(fail4)
  );

  baggage_drop_timer #(.TICK_DIV(1), .DROP_HOLD(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(st1), .t_lim_in(lm1), .drop_req(dr1),
    .drop_activated(da1), .t_act(tact1), .t_lim(tlim1), .drop_en(en1),
    .busy(busy1), .done(done1), .fail(fail1)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // t_act after drop_req is sampled k cycles after the accepted start.
  function automatic int exp_tact(input int k, input int div);
    int t;
    t = (k - 1) / div;
    return (t > 65535) ? 65535 : t;
  endfunction

  function automatic int exp_en_cycles(input bit ok, input int hold);
    return ok ? hold + 2 : 1;
  endfunction

  // Runs one start..drop cycle on the selected DUT and reports observations.
  task automatic run_cycle(input bit which, input logic [15:0] lim, input int k,
                           output logic [15:0] tact_drop, output bit frozen_ok,
                           output int en_cnt, output int done_cnt,
                           output int fail_cnt, output bit busy_ok);
    logic       c_en, c_done, c_fail, c_busy, prev_pulse;
    logic [15:0] c_tact;
    @(negedge clk);
    if (which) begin st1 = 1'b1; lm1 = lim; end
    else       begin st4 = 1'b1; lm4 = lim; end
    @(negedge clk);
    st1 = 1'b0; st4 = 1'b0;
    repeat (k - 1) @(negedge clk);
    if (which) dr1 = 1'b1; else dr4 = 1'b1;
    @(negedge clk);
    dr1 = 1'b0; dr4 = 1'b0;
    tact_drop  = which ? tact1 : tact4;
    frozen_ok  = 1'b1;
    busy_ok    = 1'b1;
    en_cnt     = 0;
    done_cnt   = 0;
    fail_cnt   = 0;
    prev_pulse = 1'b0;
    for (int i = 0; i < 12; i++) begin
      c_en   = which ? en1   : en4;
      c_done = which ? done1 : done4;
      c_fail = which ? fail1 : fail4;
      c_busy = which ? busy1 : busy4;
      c_tact = which ? tact1 : tact4;
      if (c_en) en_cnt++;
      if (c_done) done_cnt++;
      if (c_fail) fail_cnt++;
      if (c_tact !== tact_drop) frozen_ok = 1'b0;
      if (prev_pulse && c_busy !== 1'b0) busy_ok = 1'b0;
      if ((c_done || c_fail) && c_busy !== 1'b1) busy_ok = 1'b0;
      prev_pulse = c_done || c_fail;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    st4 = 1'b0; dr4 = 1'b0; lm4 = '0;
    st1 = 1'b0; dr1 = 1'b0; lm1 = '0;
    #12;
    n_chk++;
    if ({tact4, tlim4, en4, busy4, done4, fail4} !== 36'd0)
      $display("FAIL reset_outputs4 got=%h want=0", {tact4, tlim4, en4, busy4, done4, fail4});
    else n_pass++;
    n_chk++;
    if ({tact1, tlim1, en1, busy1, done1, fail1} !== 36'd0)
      $display("FAIL reset_outputs1 got=%h want=0", {tact1, tlim1, en1, busy1, done1, fail1});
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset_mid_count();
    logic busy_seen;
    @(negedge clk);
    st4 = 1'b1; lm4 = 16'd7;
    @(negedge clk);
    st4 = 1'b0;
    repeat (5) @(negedge clk);
    n_chk++;
    if (busy4 !== 1'b1) $display("FAIL count_busy got=%b want=1", busy4);
    else n_pass++;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if ({tact4, tlim4, en4, busy4, done4, fail4} !== 36'd0)
      $display("FAIL async_reset_count got=%h want=0", {tact4, tlim4, en4, busy4, done4, fail4});
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    busy_seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (busy4) busy_seen = 1'b1;
    end
    n_chk++;
    if (busy_seen !== 1'b0) $display("FAIL idle_after_reset busy_seen=%b want=0", busy_seen);
    else n_pass++;
  endtask

  task automatic test_success();
    logic [15:0] t; bit fr, bok; int ec, dc, fc; int et; bit ok;
    run_cycle(1'b0, 16'd5, 13, t, fr, ec, dc, fc, bok);
    et = exp_tact(13, 4);
    ok = (et <= 5);
    n_chk++;
    if (t !== 16'(et)) $display("FAIL success_tact got=%0d want=%0d", t, et);
    else n_pass++;
    n_chk++;
    if (!fr) $display("FAIL success_frozen got=moving want=frozen");
    else n_pass++;
    n_chk++;
    if (ec != exp_en_cycles(ok, 3)) $display("FAIL success_en_cycles got=%0d want=%0d", ec, exp_en_cycles(ok, 3));
    else n_pass++;
    n_chk++;
    if (dc != 1 || fc != 0) $display("FAIL success_pulses got done=%0d fail=%0d want done=1 fail=0", dc, fc);
    else n_pass++;
    n_chk++;
    if (!bok) $display("FAIL success_busy_fall got=bad want=falls_after_done");
    else n_pass++;
    n_chk++;
    if (tact4 !== 16'(et) || busy4 !== 1'b0)
      $display("FAIL success_idle_hold got tact=%0d busy=%b want tact=%0d busy=0", tact4, busy4, et);
    else n_pass++;
  endtask

  task automatic test_boundary();
    logic [15:0] t; bit fr, bok; int ec, dc, fc;
    run_cycle(1'b1, 16'd4, 5, t, fr, ec, dc, fc, bok);
    n_chk++;
    if (t !== 16'(exp_tact(5, 1))) $display("FAIL boundary_eq_tact got=%0d want=%0d", t, exp_tact(5, 1));
    else n_pass++;
    n_chk++;
    if (ec != exp_en_cycles(1'b1, 0) || dc != 1 || fc != 0)
      $display("FAIL boundary_eq got en=%0d done=%0d fail=%0d want en=2 done=1 fail=0", ec, dc, fc);
    else n_pass++;
    run_cycle(1'b1, 16'd4, 6, t, fr, ec, dc, fc, bok);
    n_chk++;
    if (t !== 16'(exp_tact(6, 1))) $display("FAIL boundary_late_tact got=%0d want=%0d", t, exp_tact(6, 1));
    else n_pass++;
    n_chk++;
    if (ec != exp_en_cycles(1'b0, 0) || dc != 0 || fc != 1)
      $display("FAIL boundary_late got en=%0d done=%0d fail=%0d want en=1 done=0 fail=1", ec, dc, fc);
    else n_pass++;
    n_chk++;
    if (!bok) $display("FAIL boundary_late_busy got=bad want=falls_after_fail");
    else n_pass++;
  endtask

  task automatic test_saturation();
    logic [15:0] t; bit fr, bok; int ec, dc, fc;
    run_cycle(1'b1, 16'hFFFF, 65540, t, fr, ec, dc, fc, bok);
    n_chk++;
    if (t !== 16'(exp_tact(65540, 1))) $display("FAIL sat_tact got=%h want=%h", t, exp_tact(65540, 1));
    else n_pass++;
    n_chk++;
    if (!fr || tact1 !== 16'hFFFF) $display("FAIL sat_held got=%h want=ffff", tact1);
    else n_pass++;
    n_chk++;
    if (dc != 1 || fc != 0) $display("FAIL sat_done got done=%0d fail=%0d want done=1 fail=0", dc, fc);
    else n_pass++;
  endtask

  task automatic test_ignored();
    logic en_seen, busy_seen;
    @(negedge clk);
    st4 = 1'b1; lm4 = 16'd5;
    @(negedge clk);
    st4 = 1'b0;
    repeat (3) @(negedge clk);
    st4 = 1'b1; lm4 = 16'd9;
    @(negedge clk);
    st4 = 1'b0;
    repeat (2) @(negedge clk);
    n_chk++;
    if (tlim4 !== 16'd5 || busy4 !== 1'b1)
      $display("FAIL start_in_count got tlim=%0d busy=%b want tlim=5 busy=1", tlim4, busy4);
    else n_pass++;
    dr4 = 1'b1;
    @(negedge clk);
    dr4 = 1'b0;
    repeat (12) @(negedge clk);
    en_seen = 1'b0; busy_seen = 1'b0;
    dr4 = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (en4) en_seen = 1'b1;
      if (busy4) busy_seen = 1'b1;
    end
    dr4 = 1'b0;
    n_chk++;
    if (en_seen !== 1'b0 || busy_seen !== 1'b0)
      $display("FAIL drop_req_in_idle got en=%b busy=%b want en=0 busy=0", en_seen, busy_seen);
    else n_pass++;
  endtask

  task automatic test_reset_mid_hold();
    int dcount;
    logic busy_seen;
    @(negedge clk);
    st4 = 1'b1; lm4 = 16'd100;
    @(negedge clk);
    st4 = 1'b0;
    repeat (8) @(negedge clk);
    dr4 = 1'b1;
    @(negedge clk);
    dr4 = 1'b0;
    @(negedge clk);
    n_chk++;
    if (en4 !== 1'b1 || tact4 !== 16'(exp_tact(9, 4)))
      $display("FAIL hold_entry got en=%b tact=%0d want en=1 tact=%0d", en4, tact4, exp_tact(9, 4));
    else n_pass++;
    #1 rst_n = 1'b0;
    #1;
    n_chk++;
    if (en4 !== 1'b0 || tact4 !== 16'd0 || tlim4 !== 16'd0)
      $display("FAIL async_reset_hold got en=%b tact=%0d tlim=%0d want 0 0 0", en4, tact4, tlim4);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    dcount = 0; busy_seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (done4) dcount++;
      if (busy4) busy_seen = 1'b1;
    end
    n_chk++;
    if (dcount != 0 || busy_seen !== 1'b0)
      $display("FAIL no_done_after_reset got done=%0d busy=%b want done=0 busy=0", dcount, busy_seen);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [15:0] t; bit fr, bok; int ec, dc, fc; int k, et, lim, hold, div; bit ok, w;
    for (int i = 0; i < 16; i++) begin
      w    = i[0];
      div  = w ? 1 : 4;
      hold = w ? 0 : 3;
      lim  = int'($urandom_range(0, 12));
      k    = w ? int'($urandom_range(1, 20)) : int'($urandom_range(1, 50));
      run_cycle(w, 16'(lim), k, t, fr, ec, dc, fc, bok);
      et = exp_tact(k, div);
      ok = (et <= lim);
      n_chk++;
      if (t !== 16'(et) || !fr)
        $display("FAIL rand_tact i=%0d got=%0d frozen=%b want=%0d", i, t, fr, et);
      else n_pass++;
      n_chk++;
      if (ec != exp_en_cycles(ok, hold) || dc != int'(ok) || fc != int'(!ok) || !bok)
        $display("FAIL rand_handshake i=%0d got en=%0d done=%0d fail=%0d busy_ok=%b want en=%0d done=%0d fail=%0d",
                 i, ec, dc, fc, bok, exp_en_cycles(ok, hold), int'(ok), int'(!ok));
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_count();
    test_success();
    test_boundary();
    test_ignored();
    test_reset_mid_hold();
    test_random();
    test_saturation();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
